// File: rtl/xadc_pkg.sv
// Shared types and constants for the multi-channel XADC reader.
package xadc_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, ACC} state_t;

    localparam int         ADC_W        = 12;
    localparam logic [4:0] AUX_CH_BASE  = 5'h10;
    localparam logic [6:0] DRP_AUX_BASE = 7'h10;

    // DRP status register address of auxiliary input k
    function automatic logic [6:0] aux_drp_addr(input logic [3:0] k);
        return DRP_AUX_BASE + {3'b000, k};
    endfunction

endpackage

// File: rtl/xadc_avg_bank.sv
// Per-channel accumulate/average storage with registered readout port.
// Optional peak hold is compiled in with XADC_PEAK_HOLD_EN.
module xadc_avg_bank
    import xadc_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int AVG_LOG2 = 2,
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_ch,
    input  logic [ADC_W-1:0]  wr_sample,
    input  logic [SEL_W-1:0]  sel,
    output logic              pub_valid,
    output logic [2:0]        pub_ch,
    output logic [ADC_W-1:0]  pub_data,
    output logic [NUM_CH-1:0] ch_valid,
    output logic [ADC_W-1:0]  sel_data,
    output logic [ADC_W-1:0]  sel_peak
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc    [NUM_CH];
    logic [CNT_W-1:0] cnt    [NUM_CH];
    logic [ADC_W-1:0] result [NUM_CH];

    logic [ACC_W-1:0] wr_sum;
    logic [ADC_W-1:0] wr_avg;
    logic             wr_last;
    logic             sel_ok;

    function automatic logic [ADC_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
        return ADC_W'(sum >> AVG_LOG2);
    endfunction

    always_comb begin
        wr_sum  = acc[wr_ch] + ACC_W'(wr_sample);
        wr_avg  = avg_trunc(wr_sum);
        wr_last = (AVG_LOG2 == 0) || (cnt[wr_ch] == CNT_LAST);
        sel_ok  = 32'(sel) < NUM_CH;
    end

    // ---- stage p2: accumulate / publish ----
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]    <= '0;
                cnt[i]    <= '0;
                result[i] <= '0;
            end
            pub_valid <= 1'b0;
            pub_ch    <= '0;
            pub_data  <= '0;
            ch_valid  <= '0;
            sel_data  <= '0;
        end else begin
            pub_valid <= 1'b0;
            if (wr_en) begin
                if (wr_last) begin
                    acc[wr_ch]      <= '0;
                    cnt[wr_ch]      <= '0;
                    result[wr_ch]   <= wr_avg;
                    pub_valid       <= 1'b1;
                    pub_ch          <= 3'(wr_ch);
                    pub_data        <= wr_avg;
                    ch_valid[wr_ch] <= 1'b1;
                end else begin
                    acc[wr_ch] <= wr_sum;
                    cnt[wr_ch] <= cnt[wr_ch] + 1'b1;
                end
            end
            // bypass so a freshly published average shows up with sample_valid
            if (!sel_ok)
                sel_data <= '0;
            else if (wr_en && wr_last && wr_ch == sel)
                sel_data <= wr_avg;
            else
                sel_data <= result[sel];
        end
    end

`ifdef XADC_PEAK_HOLD_EN
    logic [ADC_W-1:0] peak [NUM_CH];
    logic [ADC_W-1:0] peak_next;

    function automatic logic [ADC_W-1:0] max_u(input logic [ADC_W-1:0] a,
                                               input logic [ADC_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_comb peak_next = max_u(peak[wr_ch], wr_sample);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) peak[i] <= '0;
            sel_peak <= '0;
        end else begin
            if (wr_en) peak[wr_ch] <= peak_next;
            if (!sel_ok)
                sel_peak <= '0;
            else if (wr_en && wr_ch == sel)
                sel_peak <= peak_next;
            else
                sel_peak <= peak[sel];
        end
    end
`else
    assign sel_peak = '0;
`endif

endmodule

// File: rtl/xadc_multi_channel_reader.sv
// XADC sequencer front end: DRP read per eoc, per-channel averaging, readout port.
// Optional feature macro: XADC_PEAK_HOLD_EN (per-channel peak hold on sel_peak).
module xadc_multi_channel_reader
    import xadc_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int BASE_AUX = 5,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 64,
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              eoc_in,
    input  logic [4:0]        channel_in,
    output logic [6:0]        drp_daddr,
    output logic              drp_den,
    output logic              drp_dwe,
    input  logic [15:0]       drp_do,
    input  logic              drp_drdy,
    input  logic [SEL_W-1:0]  sel,
    output logic [11:0]       sel_data,
    output logic [11:0]       sel_peak,
    output logic              sample_valid,
    output logic [2:0]        sample_ch,
    output logic [11:0]       sample_data,
    output logic [NUM_CH-1:0] ch_valid,
    output logic              overrun,
    output logic              timeout_err
);

    localparam logic [5:0] CH_LO = 6'(AUX_CH_BASE) + 6'(BASE_AUX);
    localparam logic [5:0] CH_HI = CH_LO + 6'(NUM_CH);
    localparam int         TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state, next_state;
    logic [SEL_W-1:0] ch_idx;
    logic [TMR_W-1:0] timer;
    logic [ADC_W-1:0] sample_p1;
    logic             ch_hit;
    logic             tmr_done;
    logic             bank_wr;

    assign ch_hit   = eoc_in && ({1'b0, channel_in} >= CH_LO) && ({1'b0, channel_in} < CH_HI);
    assign tmr_done = (timer == TMR_LAST);
    assign drp_dwe  = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (ch_hit) next_state = REQ;
            REQ:  next_state = WAIT;
            WAIT: begin
                if (drp_drdy)      next_state = ACC;
                else if (tmr_done) next_state = IDLE;
            end
            ACC:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        drp_den   = 1'b0;
        drp_daddr = '0;
        bank_wr   = 1'b0;
        unique case (state)
            REQ: begin
                drp_den   = 1'b1;
                drp_daddr = aux_drp_addr(4'(BASE_AUX) + 4'(ch_idx));
            end
            ACC:     bank_wr = 1'b1;
            default: ;
        endcase
    end

    // ---- stage p1: channel latch, DRP wait, sample capture ----
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_idx      <= '0;
            timer       <= '0;
            sample_p1   <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE && ch_hit)
                ch_idx <= SEL_W'(channel_in - CH_LO[4:0]);
            if (state == REQ)
                timer <= '0;
            else if (state == WAIT)
                timer <= timer + 1'b1;
            if (state == WAIT && drp_drdy)
                sample_p1 <= ADC_W'(drp_do >> 4);
            if (eoc_in && state != IDLE)
                overrun <= 1'b1;
            if (state == WAIT && !drp_drdy && tmr_done)
                timeout_err <= 1'b1;
        end
    end

    xadc_avg_bank #(
        .NUM_CH   (NUM_CH),
        .AVG_LOG2 (AVG_LOG2)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (bank_wr),
        .wr_ch     (ch_idx),
        .wr_sample (sample_p1),
        .sel       (sel),
        .pub_valid (sample_valid),
        .pub_ch    (sample_ch),
        .pub_data  (sample_data),
        .ch_valid  (ch_valid),
        .sel_data  (sel_data),
        .sel_peak  (sel_peak)
    );

endmodule

// File: tb/tb_xadc_multi_channel_reader.sv
// Self-checking bench: directed vector table, corner sequences, random traffic vs. model.
module tb_xadc_multi_channel_reader;

    localparam int NUM_CH   = 4;
    localparam int BASE_AUX = 5;
    localparam int AVG_LOG2 = 2;
    localparam int TIMEOUT  = 64;
    localparam int NAVG     = 1 << AVG_LOG2;
    localparam int CH_FIRST = 16 + BASE_AUX;
`ifdef XADC_PEAK_HOLD_EN
    localparam logic [11:0] PEAK_FFF = 12'hFFF;
`else
    localparam logic [11:0] PEAK_FFF = 12'h000;
`endif

    logic        clk = 1'b0;
    logic        reset, eoc_in, drp_den, drp_dwe, drp_drdy;
    logic [4:0]  channel_in;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_do;
    logic [1:0]  sel;
    logic [11:0] sel_data, sel_peak, sample_data;
    logic        sample_valid, overrun, timeout_err;
    logic [2:0]  sample_ch;
    logic [3:0]  ch_valid;

    xadc_multi_channel_reader #(
        .NUM_CH(NUM_CH), .BASE_AUX(BASE_AUX), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .eoc_in(eoc_in), .channel_in(channel_in),
        .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe),
        .drp_do(drp_do), .drp_drdy(drp_drdy), .sel(sel),
        .sel_data(sel_data), .sel_peak(sel_peak), .sample_valid(sample_valid),
        .sample_ch(sample_ch), .sample_data(sample_data), .ch_valid(ch_valid),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // reference model: running sums per channel, published averages, peaks
    int         m_acc  [NUM_CH];
    int         m_cnt  [NUM_CH];
    int         m_res  [NUM_CH];
    int         m_peak [NUM_CH];
    logic [3:0] m_chv;

    typedef struct {
        logic [4:0]  ch;
        logic [15:0] dout;
        logic        exp_valid;
        logic [2:0]  exp_ch;
        logic [11:0] exp_data;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_res[i] = 0; m_peak[i] = 0;
        end
        m_chv = '0;
    endtask

    task automatic model_sample(input int c, input int s, output bit pub, output int avg);
        pub = 1'b0;
        avg = 0;
`ifdef XADC_PEAK_HOLD_EN
        if (s > m_peak[c]) m_peak[c] = s;
`endif
        m_acc[c] += s;
        m_cnt[c] += 1;
        if (m_cnt[c] == NAVG) begin
            avg       = m_acc[c] / NAVG;
            m_res[c]  = avg;
            m_acc[c]  = 0;
            m_cnt[c]  = 0;
            m_chv[c]  = 1'b1;
            pub       = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_den"},   32'(drp_den), 0);
        check({tag, "_daddr"}, 32'(drp_daddr), 0);
        check({tag, "_svalid"}, 32'(sample_valid), 0);
        check({tag, "_sch"},   32'(sample_ch), 0);
        check({tag, "_sdata"}, 32'(sample_data), 0);
        check({tag, "_chv"},   32'(ch_valid), 0);
        check({tag, "_seld"},  32'(sel_data), 0);
        check({tag, "_selp"},  32'(sel_peak), 0);
        check({tag, "_ovr"},   32'(overrun), 0);
        check({tag, "_tmo"},   32'(timeout_err), 0);
    endtask

    // one eoc/DRP transaction; returns publish outputs two cycles after drdy
    task automatic do_read(input logic [4:0] ch, input logic [15:0] dout, input int dly,
                           output logic v, output logic [2:0] c, output logic [11:0] d);
        bit in_range;
        in_range   = (int'(ch) >= CH_FIRST) && (int'(ch) < CH_FIRST + NUM_CH);
        eoc_in     = 1'b1;
        channel_in = ch;
        step();
        eoc_in = 1'b0;
        check("rd_den", 32'(drp_den), 32'(in_range));
        if (in_range) check("rd_daddr", 32'(drp_daddr), 32'({2'b00, ch}));
        step();
        check("rd_dwe", 32'(drp_dwe), 0);
        repeat (dly) step();
        drp_drdy = 1'b1;
        drp_do   = dout;
        step();
        drp_drdy = 1'b0;
        step();
        v = sample_valid;
        c = sample_ch;
        d = sample_data;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        v;
        logic [2:0]  c;
        logic [11:0] d;
        int          den_seen;

        reset = 1'b1; eoc_in = 1'b0; channel_in = '0;
        drp_do = '0; drp_drdy = 1'b0; sel = '0;
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        vecs[0] = '{5'h15, 16'h1230, 1'b0, 3'd0, 12'h000};
        vecs[1] = '{5'h15, 16'h1240, 1'b0, 3'd0, 12'h000};
        vecs[2] = '{5'h15, 16'h1250, 1'b0, 3'd0, 12'h000};
        vecs[3] = '{5'h15, 16'h1260, 1'b1, 3'd0, 12'h124};
        vecs[4] = '{5'h03, 16'hABCD, 1'b0, 3'd0, 12'h000};
        vecs[5] = '{5'h16, 16'h1000, 1'b0, 3'd0, 12'h000};
        vecs[6] = '{5'h16, 16'hFFF0, 1'b0, 3'd0, 12'h000};
        vecs[7] = '{5'h16, 16'h2000, 1'b0, 3'd0, 12'h000};
        vecs[8] = '{5'h19, 16'h7770, 1'b0, 3'd0, 12'h000};
        for (int i = 0; i < 9; i++) begin
            do_read(vecs[i].ch, vecs[i].dout, i % 3, v, c, d);
            check($sformatf("vec%0d_valid", i), 32'(v), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_ch", i), 32'(c), 32'(vecs[i].exp_ch));
                check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp_data));
            end
        end
        check("tbl_chv", 32'(ch_valid), 32'h1);
        check("tbl_sel0_data", 32'(sel_data), 32'h124);
        sel = 2'd1;
        step();
        check("tbl_sel1_data", 32'(sel_data), 0);
        check("tbl_sel1_peak", 32'(sel_peak), 32'(PEAK_FFF));
        check("tbl_ovr", 32'(overrun), 0);

        // drdy withheld: exactly TIMEOUT cycles in WAIT before giving up
        eoc_in = 1'b1; channel_in = 5'h16;
        step();
        eoc_in = 1'b0;
        check("tmo_den", 32'(drp_den), 1);
        repeat (TIMEOUT) step();
        check("tmo_not_yet", 32'(timeout_err), 0);
        step();
        check("tmo_set", 32'(timeout_err), 1);
        check("tmo_den_low", 32'(drp_den), 0);
        do_read(5'h16, 16'h0000, 2, v, c, d);
        check("tmo_next_valid", 32'(v), 1);
        check("tmo_next_ch", 32'(c), 1);
        check("tmo_next_data", 32'(d), 32'h4BF);
        check("tmo_next_seld", 32'(sel_data), 32'h4BF);
        check("tmo_chv", 32'(ch_valid), 32'h3);

        // second eoc while waiting on DRP
        sel = 2'd2;
        den_seen = 0;
        eoc_in = 1'b1; channel_in = 5'h17;
        step();
        eoc_in = 1'b0;
        den_seen += int'(drp_den);
        step();
        eoc_in = 1'b1;
        step();
        eoc_in = 1'b0;
        den_seen += int'(drp_den);
        check("ovr_flag", 32'(overrun), 1);
        step();
        den_seen += int'(drp_den);
        drp_drdy = 1'b1; drp_do = 16'h3330;
        step();
        drp_drdy = 1'b0;
        den_seen += int'(drp_den);
        step();
        den_seen += int'(drp_den);
        check("ovr_one_read", 32'(den_seen), 1);
        check("ovr_no_pub", 32'(sample_valid), 0);
        for (int i = 0; i < 3; i++) begin
            do_read(5'h17, 16'h1110, 1, v, c, d);
            check($sformatf("ovr_rd%0d_valid", i), 32'(v), (i == 2) ? 1 : 0);
        end
        check("ovr_ch", 32'(c), 2);
        check("ovr_data", 32'(d), 32'h199);
        check("ovr_sticky", 32'(overrun), 1);

        // reset in WAIT, then a stale drdy
        sel = 2'd0;
        eoc_in = 1'b1; channel_in = 5'h15;
        step();
        eoc_in = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drp_drdy = 1'b1; drp_do = 16'hFFF0;
        step();
        drp_drdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_all_zero($sformatf("rstw%0d", i));
            step();
        end

        // random traffic against the model
        model_reset();
        for (int i = 0; i < 80; i++) begin
            logic [4:0]  ch;
            logic [15:0] dout;
            bit          pub;
            int          avg;
            if ($urandom_range(0, 3) != 0) ch = 5'(CH_FIRST + $urandom_range(0, NUM_CH - 1));
            else                           ch = 5'h10 + 5'($urandom_range(0, 15));
            dout = 16'($urandom);
            do_read(ch, dout, $urandom_range(0, 5), v, c, d);
            pub = 1'b0;
            avg = 0;
            if (int'(ch) >= CH_FIRST && int'(ch) < CH_FIRST + NUM_CH)
                model_sample(int'(ch) - CH_FIRST, int'(dout[15:4]), pub, avg);
            check($sformatf("rnd%0d_valid", i), 32'(v), 32'(pub));
            if (pub) begin
                check($sformatf("rnd%0d_ch", i), 32'(c), 32'(int'(ch) - CH_FIRST));
                check($sformatf("rnd%0d_data", i), 32'(d), 32'(avg));
            end
            check($sformatf("rnd%0d_chv", i), 32'(ch_valid), 32'(m_chv));
            sel = 2'($urandom_range(0, NUM_CH - 1));
            step();
            check($sformatf("rnd%0d_seld", i), 32'(sel_data), 32'(m_res[sel]));
            check($sformatf("rnd%0d_selp", i), 32'(sel_peak), 32'(m_peak[sel]));
        end
        check("rnd_ovr", 32'(overrun), 0);
        check("rnd_tmo", 32'(timeout_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
